// File: rtl/nyancat_anim_ctrl.sv
// Animation sequencer locked to vertical blanking: drives frame_index for the
// frame-ROM address generator and executes play/pause/step/seek/rate/dir commands.
module nyancat_anim_ctrl #(
    parameter int NUM_FRAMES   = 12,
    parameter int IDX_W        = 4,
    parameter int RATE_W       = 6,
    parameter int DEFAULT_RATE = 6
) (
    input  logic             px_clk,
    input  logic             reset_n,
    input  logic             frame_start,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_arg,
    output logic [IDX_W-1:0] frame_index,
    output logic             frame_advance,
    output logic             playing,
    output logic             reverse,
    output logic             cmd_err,
    output logic [1:0]       fsm_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is low only while a STEP/SET_FRAME waits for the next frame_start.
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HOLD = 2'd1,
        S_PEND = 2'd2
    } state_t;

    localparam logic [2:0] OP_PLAY      = 3'd1;
    localparam logic [2:0] OP_PAUSE     = 3'd2;
    localparam logic [2:0] OP_STEP      = 3'd3;
    localparam logic [2:0] OP_SET_FRAME = 3'd4;
    localparam logic [2:0] OP_SET_RATE  = 3'd5;
    localparam logic [2:0] OP_SET_DIR   = 3'd6;
    localparam logic [2:0] OP_RSVD      = 3'd7;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FRAMES - 1);
    localparam logic [7:0]        NF_ARG   = 8'(NUM_FRAMES);
    localparam logic [RATE_W-1:0] RST_RATE = RATE_W'(DEFAULT_RATE);

    state_t             state_q, state_d;
    logic               playing_q, playing_d;
    logic               reverse_q, reverse_d;
    logic               pend_step_q, pend_step_d;
    logic [IDX_W-1:0]   pend_arg_q, pend_arg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RATE_W-1:0]  vcnt_q, vcnt_d;
    logic [RATE_W-1:0]  rate_q, rate_d;
    logic               adv_q, adv_d;
    logic               err_q, err_d;
    logic               accept;
    logic [IDX_W-1:0]   idx_next;
    logic [RATE_W-1:0]  arg_rate;

    assign cmd_ready     = (state_q != S_PEND);
    assign accept        = cmd_valid && cmd_ready;
    assign arg_rate      = cmd_arg[RATE_W-1:0];
    assign frame_index   = idx_q;
    assign frame_advance = adv_q;
    assign playing       = playing_q;
    assign reverse       = reverse_q;
    assign cmd_err       = err_q;
    assign fsm_state     = state_q;

    always_comb begin
        idx_next = '0;
        if (reverse_q) begin
            idx_next = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
        end else begin
            idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        playing_d   = playing_q;
        reverse_d   = reverse_q;
        pend_step_d = pend_step_q;
        pend_arg_d  = pend_arg_q;
        idx_d       = idx_q;
        vcnt_d      = vcnt_q;
        rate_d      = rate_q;
        adv_d       = 1'b0;
        err_d       = 1'b0;

        // Frame-start work sees only pre-accept state; command effects below override.
        if (frame_start) begin
            unique case (state_q)
                S_PEND: begin
                    idx_d   = pend_step_q ? idx_next : pend_arg_q;
                    vcnt_d  = '0;
                    adv_d   = 1'b1;
                    state_d = playing_q ? S_RUN : S_HOLD;
                end
                S_RUN: begin
                    if (vcnt_q == rate_q - 1'b1) begin
                        idx_d  = idx_next;
                        vcnt_d = '0;
                        adv_d  = 1'b1;
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (accept) begin
            unique case (cmd_op)
                OP_PLAY: begin
                    playing_d = 1'b1;
                    state_d   = S_RUN;
                end
                OP_PAUSE: begin
                    playing_d = 1'b0;
                    state_d   = S_HOLD;
                end
                OP_STEP: begin
                    playing_d   = 1'b0;
                    pend_step_d = 1'b1;
                    state_d     = S_PEND;
                end
                OP_SET_FRAME: begin
                    if (cmd_arg >= NF_ARG) begin
                        err_d = 1'b1;
                    end else begin
                        pend_step_d = 1'b0;
                        pend_arg_d  = cmd_arg[IDX_W-1:0];
                        state_d     = S_PEND;
                    end
                end
                OP_SET_RATE: begin
                    rate_d = (arg_rate == '0) ? RATE_W'(1) : arg_rate;
                    vcnt_d = '0;
                end
                OP_SET_DIR: reverse_d = cmd_arg[0];
                OP_RSVD:    err_d     = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_RUN;
            playing_q   <= 1'b1;
            reverse_q   <= 1'b0;
            pend_step_q <= 1'b0;
            pend_arg_q  <= '0;
            idx_q       <= '0;
            vcnt_q      <= '0;
            rate_q      <= RST_RATE;
            adv_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            playing_q   <= playing_d;
            reverse_q   <= reverse_d;
            pend_step_q <= pend_step_d;
            pend_arg_q  <= pend_arg_d;
            idx_q       <= idx_d;
            vcnt_q      <= vcnt_d;
            rate_q      <= rate_d;
            adv_q       <= adv_d;
            err_q       <= err_d;
        end
    end

    a_idx_in_range: assert property (@(posedge px_clk) disable iff (!reset_n) idx_q <= LAST_IDX);

endmodule

// File: tb/tb_nyancat_anim_ctrl.sv
// Bench for nyancat_anim_ctrl: directed scenarios plus random traffic, all
// compared each cycle against a behavioural model of the animation rules.
module tb_nyancat_anim_ctrl;
  localparam int NF = 12;

  logic       px_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_arg = 8'd0;
  logic [3:0] frame_index;
  logic       frame_advance, playing, reverse, cmd_err;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;
  bit compare_on = 1'b0;

  nyancat_anim_ctrl #(.NUM_FRAMES(NF), .IDX_W(4), .RATE_W(6), .DEFAULT_RATE(6)) dut (
    .px_clk(px_clk), .reset_n(reset_n), .frame_start(frame_start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .frame_index(frame_index), .frame_advance(frame_advance), .playing(playing),
    .reverse(reverse), .cmd_err(cmd_err), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 px_clk = ~px_clk;

  // behavioural model
  int m_idx, m_rate, m_vcnt, m_parg;
  bit m_play, m_rev, m_pend, m_pstep, m_adv, m_err;

  function automatic int step_of(int idx, bit rev);
    return rev ? (idx + NF - 1) % NF : (idx + 1) % NF;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_play = 1; m_rev = 0; m_rate = 6; m_vcnt = 0;
    m_pend = 0; m_pstep = 0; m_parg = 0; m_adv = 0; m_err = 0;
  endtask

  always @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      bit acc;
      acc = cmd_valid && !m_pend;
      m_adv = 0;
      m_err = 0;
      if (frame_start) begin
        if (m_pend) begin
          m_idx = m_pstep ? step_of(m_idx, m_rev) : m_parg;
          m_vcnt = 0; m_pend = 0; m_adv = 1;
        end else if (m_play) begin
          m_vcnt = m_vcnt + 1;
          if (m_vcnt == m_rate) begin
            m_idx = step_of(m_idx, m_rev); m_vcnt = 0; m_adv = 1;
          end
        end
      end
      if (acc) begin
        case (cmd_op)
          3'd1: m_play = 1;
          3'd2: m_play = 0;
          3'd3: begin m_play = 0; m_pend = 1; m_pstep = 1; end
          3'd4: begin
            if (cmd_arg >= NF) m_err = 1;
            else begin m_pend = 1; m_pstep = 0; m_parg = cmd_arg; end
          end
          3'd5: begin m_rate = (cmd_arg % 64 == 0) ? 1 : cmd_arg % 64; m_vcnt = 0; end
          3'd6: m_rev = cmd_arg[0];
          3'd7: m_err = 1;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, every cycle
  always @(negedge px_clk) begin
    if (compare_on) begin
      chk("frame_index", int'(frame_index), m_idx);
      chk("frame_advance", int'(frame_advance), int'(m_adv));
      chk("playing", int'(playing), int'(m_play));
      chk("reverse", int'(reverse), int'(m_rev));
      chk("cmd_ready", int'(cmd_ready), int'(!m_pend));
      chk("cmd_err", int'(cmd_err), int'(m_err));
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge px_clk);
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1;
    @(negedge px_clk);
    frame_start = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a);
    int n;
    n = 0;
    cmd_op = op; cmd_arg = a; cmd_valid = 1'b1;
    while (!cmd_ready && n < 64) begin
      @(negedge px_clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL send_timeout got cmd_ready=0 expected 1 within 64 cycles (op %0d)", op);
    end
    @(negedge px_clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    idle(3);
    compare_on = 1'b1;
    chk("rst_index", int'(frame_index), 0);
    chk("rst_playing", int'(playing), 1);
    chk("rst_ready", int'(cmd_ready), 1);
    reset_n = 1'b1;

    // 1: autoplay at default rate 6
    for (int k = 1; k <= 13; k++) begin
      idle(999);
      fs_pulse();
      if (k == 6) begin
        chk("t1_adv6", int'(frame_advance), 1);
        chk("t1_idx6", int'(frame_index), 1);
      end
      if (k == 12) chk("t1_idx12", int'(frame_index), 2);
    end
    chk("t1_idx13", int'(frame_index), 2);

    // 2: pause then step
    send(3'd2, 8'd0);
    send(3'd3, 8'd0);
    chk("t2_ready_low", int'(cmd_ready), 0);
    idle(5);
    fs_pulse();
    chk("t2_idx", int'(frame_index), 3);
    chk("t2_ready", int'(cmd_ready), 1);
    chk("t2_playing", int'(playing), 0);

    // 3: reverse wrap from frame 1 at rate 1
    send(3'd4, 8'd1);
    fs_pulse();
    chk("t3_seek1", int'(frame_index), 1);
    send(3'd6, 8'd1);
    send(3'd5, 8'd1);
    send(3'd1, 8'd0);
    idle(3);
    fs_pulse();
    chk("t3_idx0", int'(frame_index), 0);
    idle(3);
    fs_pulse();
    chk("t3_idx11", int'(frame_index), 11);

    // 4: illegal seek, then legal seek to current frame while running
    send(3'd4, 8'd12);
    chk("t4_err", int'(cmd_err), 1);
    chk("t4_ready", int'(cmd_ready), 1);
    idle(1);
    chk("t4_err_clr", int'(cmd_err), 0);
    send(3'd5, 8'd3);
    send(3'd6, 8'd0);
    fs_pulse();
    send(3'd4, 8'd11);
    idle(2);
    fs_pulse();
    chk("t4_adv", int'(frame_advance), 1);
    chk("t4_idx", int'(frame_index), 11);
    chk("t4_playing", int'(playing), 1);
    fs_pulse();
    fs_pulse();
    chk("t4_noadv", int'(frame_advance), 0);
    fs_pulse();
    chk("t4_wrap", int'(frame_index), 0);

    // 5: STEP together with a rate advance
    fs_pulse();
    fs_pulse();
    frame_start = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd3; cmd_arg = 8'd0;
    @(negedge px_clk);
    frame_start = 1'b0; cmd_valid = 1'b0;
    chk("t5_idx", int'(frame_index), 1);
    chk("t5_adv", int'(frame_advance), 1);
    chk("t5_playing", int'(playing), 0);
    chk("t5_ready", int'(cmd_ready), 0);
    idle(2);
    fs_pulse();
    chk("t5_step", int'(frame_index), 2);
    chk("t5_ready2", int'(cmd_ready), 1);

    // 6: reset while pending
    send(3'd6, 8'd1);
    send(3'd3, 8'd0);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_idx", int'(frame_index), 0);
    chk("t6_playing", int'(playing), 1);
    chk("t6_reverse", int'(reverse), 0);
    chk("t6_ready", int'(cmd_ready), 1);
    chk("t6_adv", int'(frame_advance), 0);
    idle(3);
    reset_n = 1'b1;
    idle(2);
    fs_pulse();
    chk("t6_nostep", int'(frame_index), 0);
    chk("t6_noadv", int'(frame_advance), 0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      frame_start = ($urandom_range(0, 3) == 0);
      cmd_valid   = ($urandom_range(0, 3) == 0);
      cmd_op      = 3'($urandom_range(0, 7));
      cmd_arg     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 13));
      if (c == 2500) begin
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
      @(negedge px_clk);
    end
    frame_start = 1'b0;
    cmd_valid = 1'b0;
    idle(2);
    compare_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nyancat_anim_ctrl.md
Name: nyancat_anim_ctrl

Overview:
Animation sequencer for the nyancat display datapath. It replaces the free-running clock-count frame timer with a controller that is locked to vertical blanking. It produces the frame_index consumed by the frame-ROM address generator, and it accepts play, pause, step, seek, rate and direction commands over a valid/ready handshake. frame_index changes only on a frame_start pulse, so a displayed frame never tears.

Parameters:
NUM_FRAMES, 12, number of animation frames; frame_index range is [0, NUM_FRAMES-1].
IDX_W, 4, width of frame_index; must satisfy 2^IDX_W >= NUM_FRAMES.
RATE_W, 6, width of the rate register (video frames per animation frame).
DEFAULT_RATE, 6, rate loaded at reset.

Ports:
px_clk  in  1  pixel clock; the only clock.
reset_n  in  1  asynchronous, active-low reset.
frame_start  in  1  single-cycle pulse at the start of vertical blanking, from the sync generator.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command.
cmd_op  in  3  opcode: 0 NOP, 1 PLAY, 2 PAUSE, 3 STEP, 4 SET_FRAME, 5 SET_RATE, 6 SET_DIR, 7 reserved.
cmd_arg  in  8  operand: frame number, rate, or direction in bit 0 (1 = reverse).
frame_index  out  IDX_W  current animation frame; registered.
frame_advance  out  1  one-cycle pulse in the cycle frame_index takes a new value.
playing  out  1  1 = auto-advance enabled.
reverse  out  1  1 = frame order descends.
cmd_err  out  1  one-cycle pulse when an accepted command is illegal.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - frame_index=0, playing=1 (autoplay), reverse=0.
  - rate=DEFAULT_RATE, vcnt=0, no pending command.
  - frame_advance=0, cmd_err=0, cmd_ready=1.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready on a rising edge.
  - cmd_ready = !pending, where pending is a registered flag.
  - cmd_op and cmd_arg are sampled only at acceptance.
- Immediate commands (take effect on the accept edge, pending unchanged):
  - PLAY: playing=1.
  - PAUSE: playing=0.
  - SET_RATE: rate = max(cmd_arg[RATE_W-1:0], 1), vcnt=0. An argument of 0 becomes 1.
  - SET_DIR: reverse=cmd_arg[0].
  - NOP: no effect.
  - Opcode 7: no state change; cmd_err pulses on the next cycle.
- Deferred commands:
  - STEP and SET_FRAME set pending=1 and latch the kind and argument.
  - STEP also forces playing=0 on the accept edge.
  - SET_FRAME with cmd_arg >= NUM_FRAMES is rejected: cmd_err pulses, it does not go pending, and nothing changes.
- FSM states:
  - RUN: playing=1, not pending.
  - HOLD: playing=0, not pending.
  - PEND: pending=1; playing keeps its value, so a SET_FRAME while running resumes running after the seek.
  - Transitions:
    - RUN to HOLD on PAUSE; HOLD to RUN on PLAY.
    - RUN or HOLD to PEND on an accepted STEP or legal SET_FRAME.
    - PEND to RUN or HOLD, per playing, on frame_start.
- Advance at frame_start (evaluated with the state held before the edge):
  - PEND: apply the pending command.
    - STEP: frame_index = next(frame_index).
    - SET_FRAME: frame_index = arg.
    - Then vcnt=0, pending=0, frame_advance=1.
  - RUN, with vcnt == rate-1: frame_index = next(frame_index), vcnt=0, frame_advance=1.
  - RUN, otherwise: vcnt increments.
  - HOLD: vcnt holds and frame_advance stays 0.
- Wrap-around:
  - next() forward: NUM_FRAMES-1 wraps to 0.
  - next() reverse: 0 wraps to NUM_FRAMES-1.
- Simultaneous accept and frame_start in the same cycle:
  - The frame_start is processed using pre-accept state.
  - The accepted command updates state on the same edge.
  - A deferred command accepted that cycle applies at the following frame_start.
- SET_FRAME with arg equal to the current frame still pulses frame_advance.
- Reset mid-operation discards any pending command and restores all reset values.
- Invariant: frame_index < NUM_FRAMES always. Simulation assertion required.
- frame_advance and cmd_err are never asserted together with reset active.

Test Plan:
1. Reset release; rate 6; 13 frame_start pulses 1000 cycles apart -> frame_advance on pulses 6 and 12; frame_index 0 -> 1 -> 2.
2. PAUSE then STEP with playing=0 -> cmd_ready drops the cycle after acceptance; the next frame_start moves frame_index 2 -> 3; cmd_ready returns to 1; playing stays 0.
3. SET_DIR arg=1, SET_RATE arg=1, PLAY, starting at frame_index 1 -> frame_index 0 then 11 on the next two frame_start pulses (reverse wrap).
4. SET_FRAME arg=12 -> cmd_err pulses for one cycle, no pending, frame_index unchanged. SET_FRAME arg=11 during RUN -> frame_index=11 at the next frame_start, vcnt=0, still running.
5. STEP accepted in the same cycle as a frame_start while in RUN at vcnt=rate-1 -> the rate advance happens on that edge; the step applies at the following frame_start; playing=0 afterwards.
6. Assert reset_n low while pending -> all outputs return to reset values immediately; after release cmd_ready=1 and no step is applied.
